uart_tx_arb: RTL and testbench
==============================

// Module: uart_tx_arb
// PURPOSE
//  Message-level round-robin arbiter sharing one UART TX byte stream between NUM_REQ requesters
//  (e.g. CPU console, debug monitor, DMA log). Sits in front of the TX FIFO push port of the
//  APB4 UART: tx_ready_i = ~tx FIFO full, tx_valid_o drives the push. Holds the grant for a
//  whole message (up to last byte) so bytes from different sources never interleave.
// PARAMETERS
//  NUM_REQ    4   number of requesters, 2..16
//  TO_WIDTH   16  width of stall-timeout counter/config
//  LOG_REQ    $clog2(NUM_REQ)  derived, do not override
// PORTS
//  clk_i          in   1            clock
//  rst_i          in   1            synchronous reset, active-high
//  req_valid_i    in   NUM_REQ      per-requester byte valid
//  req_data_i     in   NUM_REQ*8    per-requester byte, requester k at [8k+7:8k]
//  req_last_i     in   NUM_REQ      byte is last of message (qualified by valid)
//  req_ready_o    out  NUM_REQ      per-requester ready; only granted bit may be 1
//  tx_valid_o     out  1            byte valid to TX FIFO push
//  tx_data_o      out  8            byte to TX FIFO
//  tx_ready_i     in   1            TX FIFO not full
//  cfg_timeout_i  in   TO_WIDTH     idle-stall cycles before forced release; 0 = disabled
//  gnt_o          out  NUM_REQ      one-hot current owner (registered), 0 when idle
//  busy_o         out  1            1 while in LOCK
//  timeout_o      out  1            1-cycle pulse on forced release
// BEHAVIOUR
//  - Reset (sync, rst_i=1): state=IDLE, gnt_o=0, rr pointer=0, stall cnt=0, timeout_o=0;
//    req_ready_o=0, tx_valid_o=0, tx_data_o=0 (all comb-derived from gnt_o=0).
//  - FSM IDLE: if any req_valid_i, pick first valid index searching from ptr upward (wrap at
//    NUM_REQ-1 -> 0); register gnt_o=onehot(pick), go LOCK. No byte transfers in IDLE.
//    Arbitration latency: 1 cycle from valid to gnt_o; first byte can move in the next cycle.
//  - FSM LOCK: tx_valid_o=req_valid_i[g], tx_data_o=req_data_i[g], req_ready_o[g]=tx_ready_i
//    (combinational pass-through, zero added latency). Non-granted ready=0.
//    Handshake = tx_valid_o & tx_ready_i. Handshake with req_last_i[g]=1 -> IDLE, gnt_o=0,
//    ptr=(g+1) mod NUM_REQ. Every message costs one IDLE cycle, even back-to-back same source.
//  - Stall timeout: cnt clears on entry to LOCK and on every handshake; increments only when
//    req_valid_i[g]=0 (owner starves bus). Backpressure (valid=1, ready=0) never counts.
//    cfg_timeout_i!=0 and cnt==cfg_timeout_i-1 while incrementing -> forced release: IDLE,
//    gnt_o=0, ptr=g+1, timeout_o=1 for that one following cycle. cnt saturates, never wraps.
//  - cfg_timeout_i change mid-LOCK takes effect immediately; lowering below cnt fires at once.
//  - tx_data_o must be 0 whenever tx_valid_o=0.
//  - Owner deasserting valid mid-message is legal; grant is kept until last or timeout.
//  - Reset mid-message: drop grant silently, no timeout_o pulse, partial message is lost.
// STRUCTURE
//  - uart_define.svh gains UART_ARB_NUM_REQ default and UART_ARB_TO_WIDTH; package
//    uart_arb_pkg holds typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_e.
//  - Sub-module uart_rr_pick: combinational masked priority picker
//    (req, ptr -> onehot gnt, index, any); reusable by a future RX demux.
//  - FSM, ptr, cnt as dffr/dffer-style registers with sync active-high reset wrapper.
// TESTING
//  1 Reset: rst_i=1 for 3 cycles with all valids=1 -> gnt_o=0, tx_valid_o=0, ready=0.
//  2 Single msg: req0 sends 0x41,0x42,0x43(last), tx_ready_i=1 -> gnt_o=4'b0001 one cycle
//    after valid, FIFO sees 41,42,43 on 3 consecutive cycles, then gnt_o=0.
//  3 Fairness: req0..3 all valid with 2-byte msgs, ptr=0 -> order 0,1,2,3,0; no interleave;
//    each message followed by exactly one IDLE cycle.
//  4 Backpressure: req2 in LOCK, tx_ready_i=0 for 100 cycles, cfg_timeout_i=8 -> no timeout,
//    req_ready_o[2]=0, data held; ready=1 -> transfer resumes.
//  5 Timeout: cfg_timeout_i=8, req1 sends 1 byte no last then drops valid, req3 valid ->
//    8 stall cycles then timeout_o pulse, gnt_o moves to 4'b1000; cfg_timeout_i=0 -> never.
//  6 Reset mid-msg: rst_i during byte 2 of req1 -> next cycle gnt_o=0, ptr=0, timeout_o=0.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART TX message arbiter: default sizing and FSM encoding.
package uart_arb_pkg;

   localparam int UART_ARB_NUM_REQ  = 4;
   localparam int UART_ARB_TO_WIDTH = 16;

   typedef enum logic {
      ARB_IDLE,
      ARB_LOCK
   } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or above i_ptr, wrapping to 0.
module uart_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int LOG_REQ = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [LOG_REQ-1:0] i_ptr,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [LOG_REQ-1:0] o_idx,
   output logic               o_any
);

   logic [NUM_REQ-1:0] w_rot;
   logic [LOG_REQ-1:0] w_ofs;
   logic [LOG_REQ:0]   w_sum;

   // Rotate so the pointer position lands at bit 0, then a plain lowest-bit search suffices.
   assign w_rot = NUM_REQ'({i_req, i_req} >> i_ptr);

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      w_ofs = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (w_rot[i]) w_ofs = LOG_REQ'(i);
      end
      w_sum = {1'b0, i_ptr} + {1'b0, w_ofs};
      if (w_sum >= (LOG_REQ + 1)'(NUM_REQ)) w_sum = w_sum - (LOG_REQ + 1)'(NUM_REQ);
      o_idx        = w_sum[LOG_REQ-1:0];
      o_any        = |i_req;
      o_gnt        = '0;
      o_gnt[o_idx] = o_any;
   end

endmodule

// File: rtl/uart_tx_arb.sv
// Message-level round-robin arbiter in front of the UART TX FIFO push port.
module uart_tx_arb
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ  = UART_ARB_NUM_REQ,
   parameter int TO_WIDTH = UART_ARB_TO_WIDTH,
   parameter int LOG_REQ  = $clog2(NUM_REQ)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [NUM_REQ-1:0]   req_valid_i,
   input  logic [NUM_REQ*8-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]   req_last_i,
   output logic [NUM_REQ-1:0]   req_ready_o,
   output logic                 tx_valid_o,
   output logic [7:0]           tx_data_o,
   input  logic                 tx_ready_i,
   input  logic [TO_WIDTH-1:0]  cfg_timeout_i,
   output logic [NUM_REQ-1:0]   gnt_o,
   output logic                 busy_o,
   output logic                 timeout_o
);

   arb_state_e          r_state, w_state_n;
   logic [NUM_REQ-1:0]  r_gnt, w_gnt_n;
   logic [LOG_REQ-1:0]  r_idx, w_idx_n;
   logic [LOG_REQ-1:0]  r_ptr, w_ptr_n;
   logic [TO_WIDTH-1:0] r_cnt, w_cnt_n;
   logic                r_timeout, w_timeout_n;

   logic [NUM_REQ-1:0]  w_pick_gnt;
   logic [LOG_REQ-1:0]  w_pick_idx;
   logic                w_pick_any;
   logic                w_lock, w_hs, w_stall, w_fire;
   logic [LOG_REQ-1:0]  w_idx_inc;

   uart_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .LOG_REQ (LOG_REQ)
   ) u_pick (
      .i_req (req_valid_i),
      .i_ptr (r_ptr),
      .o_gnt (w_pick_gnt),
      .o_idx (w_pick_idx),
      .o_any (w_pick_any)
   );

   // Owner's byte stream passes straight through while locked; everything else is gated to 0.
   assign w_lock      = (r_state == ARB_LOCK);
   assign tx_valid_o  = w_lock & req_valid_i[r_idx];
   assign tx_data_o   = tx_valid_o ? req_data_i[{r_idx, 3'b000} +: 8] : 8'h00;
   assign req_ready_o = w_lock ? (r_gnt & {NUM_REQ{tx_ready_i}}) : '0;
   assign gnt_o       = r_gnt;
   assign busy_o      = w_lock;
   assign timeout_o   = r_timeout;

   assign w_hs      = tx_valid_o & tx_ready_i;
   assign w_stall   = w_lock & ~req_valid_i[r_idx];
   // ">=" rather than "==" so lowering the limit below the running count releases at once.
   assign w_fire    = w_stall & (cfg_timeout_i != '0) & (r_cnt >= cfg_timeout_i - TO_WIDTH'(1));
   assign w_idx_inc = (r_idx == LOG_REQ'(NUM_REQ - 1)) ? '0 : r_idx + LOG_REQ'(1);

   always_comb begin
      w_state_n   = r_state;
      w_gnt_n     = r_gnt;
      w_idx_n     = r_idx;
      w_ptr_n     = r_ptr;
      w_cnt_n     = r_cnt;
      w_timeout_n = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            if (w_pick_any) begin
               w_state_n = ARB_LOCK;
               w_gnt_n   = w_pick_gnt;
               w_idx_n   = w_pick_idx;
               w_cnt_n   = '0;
            end
         end
         ARB_LOCK: begin
            if (w_hs && req_last_i[r_idx]) begin
               w_state_n = ARB_IDLE;
               w_gnt_n   = '0;
               w_ptr_n   = w_idx_inc;
            end else if (w_fire) begin
               w_state_n   = ARB_IDLE;
               w_gnt_n     = '0;
               w_ptr_n     = w_idx_inc;
               w_timeout_n = 1'b1;
            end else if (w_hs) begin
               w_cnt_n = '0;
            end else if (w_stall && (r_cnt != '1)) begin
               w_cnt_n = r_cnt + TO_WIDTH'(1);
            end
         end
         default: w_state_n = ARB_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments; reset clears every control register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= ARB_IDLE;
         r_gnt     <= '0;
         r_idx     <= '0;
         r_ptr     <= '0;
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_gnt     <= w_gnt_n;
         r_idx     <= w_idx_n;
         r_ptr     <= w_ptr_n;
         r_cnt     <= w_cnt_n;
         r_timeout <= w_timeout_n;
      end
   end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: directed scenarios plus randomized traffic vs a reference model.
module tb_uart_tx_arb;

   localparam int N  = 4;
   localparam int TW = 16;

   logic            clk_i = 1'b0;
   logic            rst_i = 1'b1;
   logic [N-1:0]    req_valid_i = '0;
   logic [N*8-1:0]  req_data_i = '0;
   logic [N-1:0]    req_last_i = '0;
   logic [N-1:0]    req_ready_o;
   logic            tx_valid_o;
   logic [7:0]      tx_data_o;
   logic            tx_ready_i = 1'b0;
   logic [TW-1:0]   cfg_timeout_i = '0;
   logic [N-1:0]    gnt_o;
   logic            busy_o;
   logic            timeout_o;

   int checks   = 0;
   int failures = 0;

   uart_tx_arb #(.NUM_REQ(N), .TO_WIDTH(TW)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .req_valid_i   (req_valid_i),
      .req_data_i    (req_data_i),
      .req_last_i    (req_last_i),
      .req_ready_o   (req_ready_o),
      .tx_valid_o    (tx_valid_o),
      .tx_data_o     (tx_data_o),
      .tx_ready_i    (tx_ready_i),
      .cfg_timeout_i (cfg_timeout_i),
      .gnt_o         (gnt_o),
      .busy_o        (busy_o),
      .timeout_o     (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference model: who owns the stream, where the search starts next, how long the owner starved.
   int          m_owner = -1;
   int          m_ptr   = 0;
   int unsigned m_cnt   = 0;
   bit          m_to    = 1'b0;
   int          m_pick;

   always @(posedge clk_i) begin
      if (rst_i) begin
         m_owner = -1;
         m_ptr   = 0;
         m_cnt   = 0;
         m_to    = 1'b0;
      end else if (m_owner < 0) begin
         m_to   = 1'b0;
         m_pick = -1;
         for (int i = 0; i < N; i++)
            if (m_pick < 0 && req_valid_i[(m_ptr + i) % N]) m_pick = (m_ptr + i) % N;
         if (m_pick >= 0) begin
            m_owner = m_pick;
            m_cnt   = 0;
         end
      end else begin
         m_to = 1'b0;
         if (req_valid_i[m_owner] && tx_ready_i) begin
            if (req_last_i[m_owner]) begin
               m_ptr   = (m_owner + 1) % N;
               m_owner = -1;
            end else begin
               m_cnt = 0;
            end
         end else if (!req_valid_i[m_owner]) begin
            if (cfg_timeout_i != 0 && m_cnt + 1 >= cfg_timeout_i) begin
               m_ptr   = (m_owner + 1) % N;
               m_owner = -1;
               m_to    = 1'b1;
            end else if (m_cnt < 65535) begin
               m_cnt++;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_inputs();
      req_valid_i = '0;
      req_data_i  = '0;
      req_last_i  = '0;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      clear_inputs();
      repeat (2) step();
      rst_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i       = 1'b1;
      req_valid_i = '1;
      req_data_i  = '1;
      req_last_i  = '1;
      tx_ready_i  = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         @(negedge clk_i);
         checks++;
         if ({gnt_o, tx_valid_o, req_ready_o, tx_data_o, busy_o, timeout_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs cycle %0d: gnt=%b txv=%b rdy=%b data=%h busy=%b to=%b, want all 0",
                     c, gnt_o, tx_valid_o, req_ready_o, tx_data_o, busy_o, timeout_o);
         end
      end
      rst_i = 1'b0;
      clear_inputs();
      step();
   endtask

   task automatic test_single_msg();
      logic [7:0] bytes [3];
      bytes[0] = 8'h41; bytes[1] = 8'h42; bytes[2] = 8'h43;
      do_reset();
      tx_ready_i      = 1'b1;
      req_valid_i[0]  = 1'b1;
      req_data_i[7:0] = bytes[0];
      @(negedge clk_i);
      checks++;
      if (gnt_o !== 4'b0000 || tx_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL single_arb_latency: gnt=%b txv=%b, want gnt=0000 txv=0", gnt_o, tx_valid_o);
      end
      for (int b = 0; b < 3; b++) begin
         step();
         req_data_i[7:0] = bytes[b];
         req_last_i[0]   = (b == 2);
         @(negedge clk_i);
         checks++;
         if (gnt_o !== 4'b0001 || tx_valid_o !== 1'b1 || tx_data_o !== bytes[b] || req_ready_o !== 4'b0001) begin
            failures++;
            $display("FAIL single_byte%0d: gnt=%b txv=%b data=%h rdy=%b, want gnt=0001 txv=1 data=%h rdy=0001",
                     b, gnt_o, tx_valid_o, tx_data_o, req_ready_o, bytes[b]);
         end
      end
      step();
      clear_inputs();
      @(negedge clk_i);
      checks++;
      if (gnt_o !== 4'b0000 || busy_o !== 1'b0) begin
         failures++;
         $display("FAIL single_release: gnt=%b busy=%b, want gnt=0000 busy=0", gnt_o, busy_o);
      end
   endtask

   task automatic test_fairness();
      bit         b  [N];
      bit         hs [N];
      logic [3:0] exp_g;
      logic [7:0] exp_d;
      do_reset();
      tx_ready_i = 1'b1;
      for (int k = 0; k < N; k++) b[k] = 1'b0;
      for (int c = 0; c < 15; c++) begin
         for (int k = 0; k < N; k++) begin
            req_valid_i[k]        = 1'b1;
            req_data_i[8*k +: 8]  = {4'(k), 4'(b[k])};
            req_last_i[k]         = b[k];
         end
         @(negedge clk_i);
         // Each message is one idle cycle then two bytes; owners rotate 0,1,2,3,0.
         exp_g = (c % 3 == 0) ? 4'b0000 : 4'(1 << ((c / 3) % N));
         exp_d = (c % 3 == 0) ? 8'h00 : {4'((c / 3) % N), 4'((c % 3) - 1)};
         checks++;
         if (gnt_o !== exp_g || tx_valid_o !== (c % 3 != 0) || tx_data_o !== exp_d) begin
            failures++;
            $display("FAIL fairness cycle %0d: gnt=%b txv=%b data=%h, want gnt=%b txv=%b data=%h",
                     c, gnt_o, tx_valid_o, tx_data_o, exp_g, (c % 3 != 0), exp_d);
         end
         for (int k = 0; k < N; k++) hs[k] = req_ready_o[k] & req_valid_i[k];
         step();
         for (int k = 0; k < N; k++) if (hs[k]) b[k] = ~b[k];
      end
      clear_inputs();
   endtask

   task automatic test_backpressure();
      int bad;
      do_reset();
      cfg_timeout_i     = 16'd8;
      tx_ready_i        = 1'b0;
      req_valid_i[2]    = 1'b1;
      req_data_i[23:16] = 8'hA5;
      step();
      bad = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk_i);
         checks++;
         if (gnt_o !== 4'b0100 || req_ready_o !== 4'b0000 || tx_valid_o !== 1'b1 ||
             tx_data_o !== 8'hA5 || timeout_o !== 1'b0) begin
            failures++;
            if (bad++ < 3)
               $display("FAIL backpressure cycle %0d: gnt=%b rdy=%b txv=%b data=%h to=%b, want 0100 0000 1 a5 0",
                        c, gnt_o, req_ready_o, tx_valid_o, tx_data_o, timeout_o);
         end
         step();
      end
      tx_ready_i = 1'b1;
      @(negedge clk_i);
      checks++;
      if (req_ready_o !== 4'b0100 || tx_data_o !== 8'hA5) begin
         failures++;
         $display("FAIL backpressure_resume: rdy=%b data=%h, want rdy=0100 data=a5", req_ready_o, tx_data_o);
      end
      step();
      req_data_i[23:16] = 8'h5A;
      req_last_i[2]     = 1'b1;
      @(negedge clk_i);
      checks++;
      if (tx_data_o !== 8'h5A || gnt_o !== 4'b0100) begin
         failures++;
         $display("FAIL backpressure_second: data=%h gnt=%b, want data=5a gnt=0100", tx_data_o, gnt_o);
      end
      step();
      clear_inputs();
      @(negedge clk_i);
      checks++;
      if (gnt_o !== 4'b0000 || timeout_o !== 1'b0) begin
         failures++;
         $display("FAIL backpressure_release: gnt=%b to=%b, want 0000 0", gnt_o, timeout_o);
      end
   endtask

   task automatic test_timeout();
      int bad;
      do_reset();
      cfg_timeout_i    = 16'd8;
      tx_ready_i       = 1'b1;
      req_valid_i[1]   = 1'b1;
      req_data_i[15:8] = 8'h11;
      step();
      step();
      req_valid_i[1]    = 1'b0;
      req_valid_i[3]    = 1'b1;
      req_data_i[31:24] = 8'h33;
      req_last_i[3]     = 1'b1;
      for (int s = 1; s <= 8; s++) begin
         @(negedge clk_i);
         checks++;
         if (gnt_o !== 4'b0010 || timeout_o !== 1'b0) begin
            failures++;
            $display("FAIL timeout_stall%0d: gnt=%b to=%b, want gnt=0010 to=0", s, gnt_o, timeout_o);
         end
         step();
      end
      @(negedge clk_i);
      checks++;
      if (timeout_o !== 1'b1 || gnt_o !== 4'b0000) begin
         failures++;
         $display("FAIL timeout_pulse: to=%b gnt=%b, want to=1 gnt=0000", timeout_o, gnt_o);
      end
      step();
      @(negedge clk_i);
      checks++;
      if (gnt_o !== 4'b1000 || timeout_o !== 1'b0 || tx_data_o !== 8'h33) begin
         failures++;
         $display("FAIL timeout_next_owner: gnt=%b to=%b data=%h, want gnt=1000 to=0 data=33",
                  gnt_o, timeout_o, tx_data_o);
      end
      step();
      clear_inputs();
      // Disabled timeout: owner may starve the bus indefinitely.
      cfg_timeout_i    = '0;
      req_valid_i[1]   = 1'b1;
      req_data_i[15:8] = 8'h12;
      step();
      step();
      req_valid_i[1] = 1'b0;
      req_valid_i[3] = 1'b1;
      bad = 0;
      for (int s = 0; s < 40; s++) begin
         @(negedge clk_i);
         checks++;
         if (gnt_o !== 4'b0010 || timeout_o !== 1'b0) begin
            failures++;
            if (bad++ < 3)
               $display("FAIL timeout_disabled stall %0d: gnt=%b to=%b, want gnt=0010 to=0", s, gnt_o, timeout_o);
         end
         step();
      end
      // Re-enabling with a limit below the accumulated stall count releases immediately.
      cfg_timeout_i = 16'd8;
      step();
      @(negedge clk_i);
      checks++;
      if (timeout_o !== 1'b1 || gnt_o !== 4'b0000) begin
         failures++;
         $display("FAIL timeout_lowered: to=%b gnt=%b, want to=1 gnt=0000", timeout_o, gnt_o);
      end
      clear_inputs();
      cfg_timeout_i = '0;
      step();
   endtask

   task automatic test_reset_mid_msg();
      do_reset();
      tx_ready_i        = 1'b1;
      req_valid_i[2]    = 1'b1;
      req_last_i[2]     = 1'b1;
      req_data_i[23:16] = 8'h77;
      step();
      step();
      clear_inputs();
      req_valid_i[1]   = 1'b1;
      req_data_i[15:8] = 8'h21;
      step();
      step();
      req_data_i[15:8] = 8'h22;
      @(negedge clk_i);
      checks++;
      if (gnt_o !== 4'b0010 || tx_data_o !== 8'h22) begin
         failures++;
         $display("FAIL resetmid_setup: gnt=%b data=%h, want gnt=0010 data=22", gnt_o, tx_data_o);
      end
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      req_valid_i = '1;
      @(negedge clk_i);
      checks++;
      if (gnt_o !== 4'b0000 || timeout_o !== 1'b0 || busy_o !== 1'b0) begin
         failures++;
         $display("FAIL resetmid_drop: gnt=%b to=%b busy=%b, want 0000 0 0", gnt_o, timeout_o, busy_o);
      end
      step();
      @(negedge clk_i);
      checks++;
      if (gnt_o !== 4'b0001) begin
         failures++;
         $display("FAIL resetmid_ptr: gnt=%b, want 0001", gnt_o);
      end
      clear_inputs();
      step();
   endtask

   task automatic test_random(input int cycles, input int cfg);
      logic [3:0] exp_g, exp_r;
      logic       exp_v;
      logic [7:0] exp_d;
      int         bad;
      do_reset();
      cfg_timeout_i = TW'(cfg);
      bad = 0;
      for (int c = 0; c < cycles; c++) begin
         for (int k = 0; k < N; k++) begin
            req_valid_i[k]       = ($urandom_range(0, 9) < 6);
            req_data_i[8*k +: 8] = 8'($urandom);
            req_last_i[k]        = ($urandom_range(0, 3) == 0);
         end
         tx_ready_i = ($urandom_range(0, 3) != 0);
         @(negedge clk_i);
         exp_g = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
         exp_v = (m_owner >= 0) ? req_valid_i[m_owner] : 1'b0;
         exp_d = exp_v ? req_data_i[8*m_owner +: 8] : 8'h00;
         exp_r = tx_ready_i ? exp_g : 4'b0000;
         checks++;
         if ({gnt_o, tx_valid_o, tx_data_o, req_ready_o, busy_o, timeout_o} !==
             {exp_g, exp_v, exp_d, exp_r, (m_owner >= 0), m_to}) begin
            failures++;
            if (bad++ < 5)
               $display("FAIL random cfg=%0d cycle %0d: gnt=%b v=%b d=%h rdy=%b busy=%b to=%b, want %b %b %h %b %b %b",
                        cfg, c, gnt_o, tx_valid_o, tx_data_o, req_ready_o, busy_o, timeout_o,
                        exp_g, exp_v, exp_d, exp_r, (m_owner >= 0), m_to);
         end
         step();
      end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_single_msg();
      test_fairness();
      test_backpressure();
      test_timeout();
      test_reset_mid_msg();
      test_random(800, 3);
      test_random(800, 0);
      test_random(600, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
